// File: rtl/load_extend_ctrl.sv
// Multi-cycle load unit for the MIPS_32 memory stage: issues a word-aligned read
// over a req/ack handshake, extracts the addressed lane and sign/zero-extends it.
module load_extend_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned RD_W        = 5,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [1:0]        ld_size,
    input  logic              ld_unsigned,
    input  logic [RD_W-1:0]   ld_rd,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic              exc_valid,
    output logic [1:0]        exc_code,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE,
        ST_EXC
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b10;
    localparam logic [1:0] EXC_ILLSIZE  = 2'b11;

    // Counter value at which the final allowed request cycle is being sampled.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
    logic [1:0]        exc_code_q, exc_code_d;

    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic [31:0]       ext_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            rd_q       <= '0;
            cnt_q      <= '0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            exc_code_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            exc_code_q <= exc_code_d;
        end
    end

    // Lane extraction and extension of the incoming read word.
    always_comb begin
        lane_byte = 8'h00;
        case (addr_q[1:0])
            2'b00:   lane_byte = mem_rdata[7:0];
            2'b01:   lane_byte = mem_rdata[15:8];
            2'b10:   lane_byte = mem_rdata[23:16];
            default: lane_byte = mem_rdata[31:24];
        endcase
        lane_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        ext_data = mem_rdata;
        case (size_q)
            SZ_BYTE: ext_data = uns_q ? {24'h000000, lane_byte}
                                      : {{24{lane_byte[7]}}, lane_byte};
            SZ_HALF: ext_data = uns_q ? {16'h0000, lane_half}
                                      : {{16{lane_half[15]}}, lane_half};
            default: ext_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        uns_d      = uns_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        exc_code_d = exc_code_q;

        case (state_q)
            ST_IDLE: begin
                if (ld_valid) begin
                    addr_d = ld_addr;
                    size_d = ld_size;
                    uns_d  = ld_unsigned;
                    rd_d   = ld_rd;
                    if (ld_size == SZ_ILL) begin
                        exc_code_d = EXC_ILLSIZE;
                        state_d    = ST_EXC;
                    end else if ((ld_size == SZ_HALF && ld_addr[0]) ||
                                 (ld_size == SZ_WORD && ld_addr[1:0] != 2'b00)) begin
                        exc_code_d = EXC_MISALIGN;
                        state_d    = ST_EXC;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // An ack on the last allowed cycle takes priority over the timeout.
                if (mem_ack) begin
                    wb_data_d = ext_data;
                    wb_rd_d   = rd_q;
                    state_d   = ST_DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    exc_code_d = EXC_TIMEOUT;
                    state_d    = ST_EXC;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_EXC:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign ld_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign mem_req   = (state_q == ST_REQ);
    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign wb_valid  = (state_q == ST_DONE);
    assign exc_valid = (state_q == ST_EXC);
    assign wb_data   = wb_data_q;
    assign wb_rd     = wb_rd_q;
    assign exc_code  = exc_code_q;

endmodule
